param_byte_packer: RTL

- Front-end stage that feeds the ResNet18 top-level parameter/image input port.
- Collects an 8-bit byte stream from the host link (UART/DMA byte interface) and assembles WIDTH_P-bit words, LSB byte first.
- Buffers assembled words in a first-word-fall-through FIFO and presents them on a ready/valid stream that connects directly to the top's i_valid/i_tdata/o_ready.
- Drops stalled partial words on an inter-byte timeout so a broken host transfer cannot misalign every word that follows.

---
 rtl/param_byte_packer_if.sv | 31 +++
 rtl/param_byte_packer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/param_byte_packer_if.sv
// ============================================================================
// Module  : param_byte_packer_if
// Brief   : Host byte stream in, assembled word stream out, plus status.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface param_byte_packer_if #(
    parameter int WIDTH_P = 32
);
    logic               i_byte_vld;
    logic [7:0]         i_byte;
    logic               o_byte_rdy;
    logic               o_valid;
    logic [WIDTH_P-1:0] o_tdata;
    logic               i_ready;
    logic [31:0]        o_word_cnt;
    logic               o_err_timeout;

    modport slave (
        input  i_byte_vld, i_byte, i_ready,
        output o_byte_rdy, o_valid, o_tdata, o_word_cnt, o_err_timeout
    );

    modport master (
        output i_byte_vld, i_byte, i_ready,
        input  o_byte_rdy, o_valid, o_tdata, o_word_cnt, o_err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/param_byte_packer.sv
// ============================================================================
// Module  : param_byte_packer
// Brief   : Packs host bytes LSB-first into words, queues them in an FWFT FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module param_byte_packer #(
    parameter int WIDTH_P    = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 i_sclk,
    input  logic                 i_rstp,
    param_byte_packer_if.slave   bus
);
    localparam int BYTES = WIDTH_P / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [WIDTH_P-1:0] shift_q,    shift_d;
    logic [TMO_W-1:0]   tmo_q,      tmo_d;
    logic               err_q,      err_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [31:0]        word_cnt_q, word_cnt_d;
    logic [WIDTH_P-1:0] mem_q [FIFO_DEPTH];

    logic               w_last;
    logic               w_full;
    logic               w_not_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH_P-1:0] w_word;

    assign w_last      = (idx_q == LAST_IDX);
    assign w_full      = (count_q == FULL_CNT);
    assign w_not_empty = (count_q != '0);

    // Only the word-completing byte ever waits on FIFO space.
    assign bus.o_byte_rdy = !i_rstp && !(w_full && w_last);

    assign w_accept = bus.i_byte_vld && bus.o_byte_rdy;
    assign w_push   = w_accept && w_last;
    assign w_pop    = w_not_empty && bus.i_ready;

    assign bus.o_valid       = w_not_empty;
    assign bus.o_tdata       = w_not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.o_word_cnt    = word_cnt_q;
    assign bus.o_err_timeout = err_q;

    always_comb begin
        w_word = shift_q;
        for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_word[8*k +: 8] = bus.i_byte;
            end
        end
    end

    always_comb begin
        idx_d      = idx_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;

        // An accepted byte takes priority over an expiring timeout.
        if (w_accept) begin
            tmo_d = '0;
            if (w_last) begin
                idx_d   = '0;
                shift_d = '0;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                shift_d = w_word;
            end
        end else if (idx_q == '0) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            idx_d   = '0;
            shift_d = '0;
            tmo_d   = '0;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            word_cnt_d = word_cnt_q + 32'd1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rstp) begin
            idx_q      <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge i_sclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

endmodule

`default_nettype wire
